// File: rtl/tap_chain_mux.sv
// JTAG TAP selector: routes the pad TAP port to one of NUM_TAPS downstream TAPs or chains them all,
// switching only when a shadow TAP state machine shows everything is safely in Test-Logic-Reset.
module tap_chain_mux #(
  parameter int NUM_TAPS = 2,
  parameter int SEL_W    = 2,
  parameter bit CHAIN_EN = 1'b1
) (
  input  logic                pad_tap_tck,
  input  logic                tap_rst,
  input  logic [SEL_W-1:0]    pad_sel_tap,
  input  logic                pad_tap_tms,
  input  logic                pad_tap_trst_n,
  input  logic                pad_tap_tdi,
  output logic                pad_tap_tdo,
  output logic                pad_tap_tdo_en,
  output logic                mux_tap_trst_n,
  output logic [NUM_TAPS-1:0] mux_tap_tms,
  output logic [NUM_TAPS-1:0] mux_tap_tdi,
  input  logic [NUM_TAPS-1:0] mux_tap_tdo,
  output logic [SEL_W-1:0]    act_sel,
  output logic                sel_pending,
  output logic                sel_invalid,
  output logic [3:0]          tap_state
);

  typedef enum logic [3:0] {
    TLR     = 4'hF, RTI     = 4'hC, SEL_DR  = 4'h7, CAP_DR  = 4'h6,
    SH_DR   = 4'h2, EX1_DR  = 4'h1, PAUSE_DR = 4'h3, EX2_DR = 4'h0,
    UPD_DR  = 4'h5, SEL_IR  = 4'h4, CAP_IR  = 4'hE, SH_IR   = 4'hA,
    EX1_IR  = 4'h9, PAUSE_IR = 4'hB, EX2_IR = 4'h8, UPD_IR  = 4'hD
  } tap_state_e;

  localparam logic [SEL_W-1:0] CHAIN_CODE = '1;
  localparam logic [SEL_W-1:0] NUM_TAPS_C = SEL_W'(NUM_TAPS);
  localparam logic [2:0]       PARK_LOAD  = 3'd5;

  tap_state_e                 state_q, state_d;
  logic [SEL_W-1:0]           act_sel_q, act_sel_d;
  logic [NUM_TAPS-1:0][2:0]   park_q, park_d;

  logic chain_mode;
  logic req_chain;
  logic sel_legal;
  logic target_parked;
  logic switch_ok;

  assign mux_tap_trst_n = pad_tap_trst_n;
  assign act_sel        = act_sel_q;
  assign tap_state      = state_q;

  assign chain_mode  = CHAIN_EN && (act_sel_q == CHAIN_CODE);
  assign req_chain   = CHAIN_EN && (pad_sel_tap == CHAIN_CODE);
  assign sel_legal   = (pad_sel_tap < NUM_TAPS_C) || req_chain;
  assign sel_invalid = !sel_legal;
  assign sel_pending = !tap_rst && sel_legal && (pad_sel_tap != act_sel_q);
  assign pad_tap_tdo_en = !tap_rst && ((state_q == SH_DR) || (state_q == SH_IR));

  // Pad routing follows act_sel combinationally; idle TAPs see TMS=1 so they sit in TLR.
  always_comb begin
    mux_tap_tms = '1;
    mux_tap_tdi = {NUM_TAPS{pad_tap_tdi}};
    pad_tap_tdo = mux_tap_tdo[0];
    if (!tap_rst) begin
      if (chain_mode) begin
        mux_tap_tms = {NUM_TAPS{pad_tap_tms}};
        mux_tap_tdi = {mux_tap_tdo[NUM_TAPS-2:0], pad_tap_tdi};
        pad_tap_tdo = mux_tap_tdo[NUM_TAPS-1];
      end else begin
        for (int i = 0; i < NUM_TAPS; i++) begin
          if (act_sel_q == SEL_W'(i)) begin
            mux_tap_tms[i] = pad_tap_tms;
            pad_tap_tdo    = mux_tap_tdo[i];
          end
        end
      end
    end
  end

  // A TAP counts as parked after five consecutive TMS=1 clocks, which guarantees it reached TLR.
  always_comb begin
    target_parked = 1'b0;
    if (req_chain) begin
      target_parked = 1'b1;
      for (int i = 0; i < NUM_TAPS; i++) begin
        if (park_q[i] < PARK_LOAD) target_parked = 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        if (pad_sel_tap == SEL_W'(i)) target_parked = (park_q[i] >= PARK_LOAD);
      end
    end
    switch_ok = sel_legal && (pad_sel_tap != act_sel_q) && (state_q == TLR) && target_parked;
    act_sel_d = switch_ok ? pad_sel_tap : act_sel_q;
  end

  always_comb begin
    park_d = park_q;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (!pad_tap_trst_n)     park_d[i] = PARK_LOAD;
      else if (!mux_tap_tms[i]) park_d[i] = 3'd0;
      else if (park_q[i] != 3'd7) park_d[i] = park_q[i] + 3'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:      state_d = pad_tap_tms ? TLR    : RTI;
      RTI:      state_d = pad_tap_tms ? SEL_DR : RTI;
      SEL_DR:   state_d = pad_tap_tms ? SEL_IR : CAP_DR;
      CAP_DR:   state_d = pad_tap_tms ? EX1_DR : SH_DR;
      SH_DR:    state_d = pad_tap_tms ? EX1_DR : SH_DR;
      EX1_DR:   state_d = pad_tap_tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_d = pad_tap_tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_d = pad_tap_tms ? UPD_DR : SH_DR;
      UPD_DR:   state_d = pad_tap_tms ? SEL_DR : RTI;
      SEL_IR:   state_d = pad_tap_tms ? TLR    : CAP_IR;
      CAP_IR:   state_d = pad_tap_tms ? EX1_IR : SH_IR;
      SH_IR:    state_d = pad_tap_tms ? EX1_IR : SH_IR;
      EX1_IR:   state_d = pad_tap_tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_d = pad_tap_tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_d = pad_tap_tms ? UPD_IR : SH_IR;
      UPD_IR:   state_d = pad_tap_tms ? SEL_DR : RTI;
      default:  state_d = TLR;
    endcase
    if (!pad_tap_trst_n) state_d = TLR;
  end

  always_ff @(posedge pad_tap_tck) begin
    if (tap_rst) begin
      state_q   <= TLR;
      act_sel_q <= '0;
      park_q    <= {NUM_TAPS{PARK_LOAD}};
    end else begin
      state_q   <= state_d;
      act_sel_q <= act_sel_d;
      park_q    <= park_d;
    end
  end

endmodule

// File: tb/tb_tap_chain_mux.sv
// Directed bench for tap_chain_mux with three TAPs and a 3-bit select (code 7 = chain, 3..6 illegal).
module tb_tap_chain_mux;

  localparam int NUM_TAPS = 3;
  localparam int SEL_W    = 3;

  logic                pad_tap_tck = 1'b0;
  logic                tap_rst;
  logic [SEL_W-1:0]    pad_sel_tap;
  logic                pad_tap_tms;
  logic                pad_tap_trst_n;
  logic                pad_tap_tdi;
  logic                pad_tap_tdo;
  logic                pad_tap_tdo_en;
  logic                mux_tap_trst_n;
  logic [NUM_TAPS-1:0] mux_tap_tms;
  logic [NUM_TAPS-1:0] mux_tap_tdi;
  logic [NUM_TAPS-1:0] mux_tap_tdo;
  logic [SEL_W-1:0]    act_sel;
  logic                sel_pending;
  logic                sel_invalid;
  logic [3:0]          tap_state;

  int compared   = 0;
  int mismatched = 0;

  tap_chain_mux #(.NUM_TAPS(NUM_TAPS), .SEL_W(SEL_W), .CHAIN_EN(1'b1)) u_dut (
    .pad_tap_tck    (pad_tap_tck),
    .tap_rst        (tap_rst),
    .pad_sel_tap    (pad_sel_tap),
    .pad_tap_tms    (pad_tap_tms),
    .pad_tap_trst_n (pad_tap_trst_n),
    .pad_tap_tdi    (pad_tap_tdi),
    .pad_tap_tdo    (pad_tap_tdo),
    .pad_tap_tdo_en (pad_tap_tdo_en),
    .mux_tap_trst_n (mux_tap_trst_n),
    .mux_tap_tms    (mux_tap_tms),
    .mux_tap_tdi    (mux_tap_tdi),
    .mux_tap_tdo    (mux_tap_tdo),
    .act_sel        (act_sel),
    .sel_pending    (sel_pending),
    .sel_invalid    (sel_invalid),
    .tap_state      (tap_state)
  );

  always #5 pad_tap_tck = ~pad_tap_tck;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic tms);
    pad_tap_tms = tms;
    @(posedge pad_tap_tck);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    tap_rst        = 1'b1;
    pad_sel_tap    = 3'd0;
    pad_tap_tms    = 1'b0;
    pad_tap_trst_n = 1'b1;
    pad_tap_tdi    = 1'b0;
    mux_tap_tdo    = 3'b110;
    #1;
    checkOutput("rst_tms_forced", 32'(mux_tap_tms), 32'h7);
    checkOutput("trst_passthru_hi", 32'(mux_tap_trst_n), 32'h1);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("rst_act_sel", 32'(act_sel), 32'h0);
    checkOutput("rst_state", 32'(tap_state), 32'hF);
    checkOutput("rst_pending", 32'(sel_pending), 32'h0);
    checkOutput("rst_tdo_en", 32'(pad_tap_tdo_en), 32'h0);
    checkOutput("rst_tdo_tap0", 32'(pad_tap_tdo), 32'h0);
    checkOutput("rst_tms_held", 32'(mux_tap_tms), 32'h7);

    tap_rst = 1'b0;
    #1;
    checkOutput("single0_tms_lo", 32'(mux_tap_tms), 32'h6);
    pad_tap_tms = 1'b1;
    #1;
    checkOutput("single0_tms_hi", 32'(mux_tap_tms), 32'h7);

    applyStimulus(1'b0);
    checkOutput("walk_rti", 32'(tap_state), 32'hC);
    applyStimulus(1'b1);
    checkOutput("walk_seldr", 32'(tap_state), 32'h7);
    applyStimulus(1'b0);
    checkOutput("walk_capdr", 32'(tap_state), 32'h6);
    applyStimulus(1'b0);
    checkOutput("walk_shdr", 32'(tap_state), 32'h2);
    checkOutput("shdr_tdo_en", 32'(pad_tap_tdo_en), 32'h1);
    pad_tap_tdi = 1'b1;
    mux_tap_tdo = 3'b001;
    #1;
    checkOutput("single0_tdi", 32'(mux_tap_tdi), 32'h7);
    checkOutput("single0_tdo", 32'(pad_tap_tdo), 32'h1);

    // Request TAP 1 mid-shift, then walk out to TLR.
    pad_sel_tap = 3'd1;
    #1;
    checkOutput("req1_pending", 32'(sel_pending), 32'h1);
    checkOutput("req1_valid", 32'(sel_invalid), 32'h0);
    applyStimulus(1'b1);
    checkOutput("walk_ex1dr", 32'(tap_state), 32'h1);
    checkOutput("ex1dr_tdo_en", 32'(pad_tap_tdo_en), 32'h0);
    applyStimulus(1'b1);
    checkOutput("walk_upddr", 32'(tap_state), 32'h5);
    applyStimulus(1'b1);
    checkOutput("walk_seldr2", 32'(tap_state), 32'h7);
    applyStimulus(1'b1);
    checkOutput("walk_selir", 32'(tap_state), 32'h4);
    checkOutput("selir_hold", 32'(act_sel), 32'h0);
    applyStimulus(1'b1);
    checkOutput("walk_tlr", 32'(tap_state), 32'hF);
    checkOutput("tlr_hold", 32'(act_sel), 32'h0);
    checkOutput("tlr_pending", 32'(sel_pending), 32'h1);
    applyStimulus(1'b1);
    checkOutput("switch1_act", 32'(act_sel), 32'h1);
    checkOutput("switch1_pending", 32'(sel_pending), 32'h0);
    mux_tap_tdo = 3'b010;
    #1;
    checkOutput("single1_tdo_hi", 32'(pad_tap_tdo), 32'h1);
    mux_tap_tdo = 3'b101;
    pad_tap_tms = 1'b0;
    #1;
    checkOutput("single1_tdo_lo", 32'(pad_tap_tdo), 32'h0);
    checkOutput("single1_tms", 32'(mux_tap_tms), 32'h5);

    // Illegal code is flagged, never pending, never applied.
    pad_sel_tap = 3'd5;
    #1;
    checkOutput("code5_invalid", 32'(sel_invalid), 32'h1);
    checkOutput("code5_pending", 32'(sel_pending), 32'h0);
    applyStimulus(1'b1);
    checkOutput("code5_hold", 32'(act_sel), 32'h1);

    // Chain mode.
    pad_sel_tap = 3'd7;
    #1;
    checkOutput("code7_valid", 32'(sel_invalid), 32'h0);
    checkOutput("code7_pending", 32'(sel_pending), 32'h1);
    applyStimulus(1'b1);
    checkOutput("chain_act", 32'(act_sel), 32'h7);
    pad_tap_tms = 1'b0;
    #1;
    checkOutput("chain_tms", 32'(mux_tap_tms), 32'h0);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("chain_shdr", 32'(tap_state), 32'h2);
    checkOutput("chain_tdo_en", 32'(pad_tap_tdo_en), 32'h1);
    pad_tap_tdi = 1'b1;
    mux_tap_tdo = 3'b010;
    #1;
    checkOutput("chain_tdi_a", 32'(mux_tap_tdi), 32'h5);
    checkOutput("chain_tdo_a", 32'(pad_tap_tdo), 32'h0);
    mux_tap_tdo = 3'b100;
    #1;
    checkOutput("chain_tdi_b", 32'(mux_tap_tdi), 32'h1);
    checkOutput("chain_tdo_b", 32'(pad_tap_tdo), 32'h1);

    // Only three TMS=1 clocks before reaching TLR: TAPs are not yet parked.
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("chain_tlr", 32'(tap_state), 32'hF);
    pad_sel_tap = 3'd2;
    #1;
    checkOutput("req2_pending", 32'(sel_pending), 32'h1);
    applyStimulus(1'b1);
    checkOutput("park3_block", 32'(act_sel), 32'h7);
    applyStimulus(1'b1);
    checkOutput("park4_block", 32'(act_sel), 32'h7);
    applyStimulus(1'b1);
    checkOutput("park5_switch", 32'(act_sel), 32'h2);
    checkOutput("park5_pending", 32'(sel_pending), 32'h0);

    // TRST in ShIR reloads park counters so the chain request can go through.
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("walk_shir", 32'(tap_state), 32'hA);
    checkOutput("shir_tdo_en", 32'(pad_tap_tdo_en), 32'h1);
    pad_sel_tap    = 3'd7;
    pad_tap_trst_n = 1'b0;
    #1;
    checkOutput("trst_passthru_lo", 32'(mux_tap_trst_n), 32'h0);
    checkOutput("shir_pending", 32'(sel_pending), 32'h1);
    applyStimulus(1'b0);
    checkOutput("trst_state", 32'(tap_state), 32'hF);
    checkOutput("trst_hold", 32'(act_sel), 32'h2);
    pad_tap_trst_n = 1'b1;
    applyStimulus(1'b1);
    checkOutput("trst_switch", 32'(act_sel), 32'h7);

    pad_sel_tap = 3'd1;
    applyStimulus(1'b1);
    checkOutput("back_to1", 32'(act_sel), 32'h1);

    // A request withdrawn before it applies leaves nothing pending.
    applyStimulus(1'b0);
    pad_sel_tap = 3'd0;
    #1;
    checkOutput("revert_req", 32'(sel_pending), 32'h1);
    pad_sel_tap = 3'd1;
    #1;
    checkOutput("revert_clear", 32'(sel_pending), 32'h0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("rst_pre_shdr", 32'(tap_state), 32'h2);
    checkOutput("rst_pre_act", 32'(act_sel), 32'h1);

    // Reset mid-shift.
    tap_rst = 1'b1;
    #1;
    checkOutput("midrst_tms_comb", 32'(mux_tap_tms), 32'h7);
    mux_tap_tdo = 3'b001;
    applyStimulus(1'b0);
    checkOutput("midrst_act", 32'(act_sel), 32'h0);
    checkOutput("midrst_state", 32'(tap_state), 32'hF);
    checkOutput("midrst_tms", 32'(mux_tap_tms), 32'h7);
    checkOutput("midrst_tdo", 32'(pad_tap_tdo), 32'h1);
    checkOutput("midrst_tdo_en", 32'(pad_tap_tdo_en), 32'h0);
    tap_rst = 1'b0;
    applyStimulus(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tap_chain_mux.md
# tap_chain_mux

Parametrised JTAG TAP selector for the testchip IO ring. It routes one shared pad TAP port to one of NUM_TAPS downstream TAP controllers, or daisy-chains all of them in series. A shadow IEEE 1149.1 TAP state machine tracks the pad TMS stream, so a selection change only takes effect when every TAP is known to be in Test-Logic-Reset. It sits between the pad ring and the PHY/testchip TAP controllers and replaces the fixed two-way TAP mux.

## Interface
Parameters:
- NUM_TAPS, 2: number of downstream TAP controllers, legal range 2..15.
- SEL_W, 2: width of the select input; must satisfy 2^SEL_W > NUM_TAPS.
- CHAIN_EN, 1: when 1, select code 2^SEL_W-1 selects chain mode.

Ports:
- pad_tap_tck, in, 1: TAP clock; the block's only clock; all flops rise on it.
- tap_rst, in, 1: reset, synchronous, active-high.
- pad_sel_tap, in, SEL_W: requested TAP select.
- pad_tap_tms, in, 1: pad TMS.
- pad_tap_trst_n, in, 1: pad TRST_N; passed through, and also sampled synchronously.
- pad_tap_tdi, in, 1: pad TDI.
- pad_tap_tdo, out, 1: TDO returned to the pad.
- pad_tap_tdo_en, out, 1: pad TDO output enable.
- mux_tap_trst_n, out, 1: TRST_N to all TAPs, equal to pad_tap_trst_n.
- mux_tap_tms, out, NUM_TAPS: per-TAP TMS.
- mux_tap_tdi, out, NUM_TAPS: per-TAP TDI.
- mux_tap_tdo, in, NUM_TAPS: per-TAP TDO.
- act_sel, out, SEL_W: currently applied selection.
- sel_pending, out, 1: requested selection differs from act_sel and has not yet been applied.
- sel_invalid, out, 1: pad_sel_tap is not a legal code (combinational).
- tap_state, out, 4: shadow TAP state.

## Operation
- Shadow FSM: the 16-state IEEE 1149.1 diagram, advanced by pad_tap_tms on every clock.
  - Encoding: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
  - pad_tap_trst_n sampled low forces the next state to TLR.
- Legal select codes:
  - 0..NUM_TAPS-1.
  - 2^SEL_W-1 when CHAIN_EN=1 (chain mode).
  - All other codes raise sel_invalid, are never applied and never set sel_pending.
- Park counters: one 3-bit saturating counter per TAP.
  - Increments on every clock in which that TAP's mux_tap_tms=1.
  - Clears when that TAP's mux_tap_tms=0.
  - A TAP is "parked" when its count is ≥5.
  - Reset or sampled pad_tap_trst_n=0 loads 5 into every counter.
- Switch rule: act_sel <= pad_sel_tap at a rising edge only when all of the following hold; otherwise sel_pending=1 and act_sel holds.
  - The code is legal.
  - It differs from act_sel.
  - tap_state==TLR.
  - Every TAP that will receive pad TMS after the switch is parked.
- Single-TAP mode (act_sel=k):
  - mux_tap_tms[k]=pad_tap_tms; all other mux_tap_tms=1.
  - All mux_tap_tdi=pad_tap_tdi.
  - pad_tap_tdo=mux_tap_tdo[k].
- Chain mode:
  - All mux_tap_tms=pad_tap_tms.
  - mux_tap_tdi[0]=pad_tap_tdi; mux_tap_tdi[i]=mux_tap_tdo[i-1].
  - pad_tap_tdo=mux_tap_tdo[NUM_TAPS-1].
- pad_tap_tdo_en=1 iff tap_state is ShDR or ShIR.
- Reset values:
  - act_sel=0; tap_state=TLR; sel_pending=0; pad_tap_tdo_en=0.
  - While tap_rst=1, all mux_tap_tms=1.
  - pad_tap_tdo follows mux_tap_tdo[0].
  - mux_tap_trst_n and sel_invalid are not affected by reset.

## Timing
- TMS, TDI and TDO muxing is combinational from act_sel (0 cycles). act_sel, tap_state and the counters are registered.
- Switch latency:
  - Applied at the first rising edge where the switch rule holds.
  - The new routing is visible immediately after that edge.
  - sel_pending is combinational and drops in the same cycle.
- The select request is not latched. If pad_sel_tap changes back to act_sel while a switch is pending, sel_pending clears and nothing switches.
- Simultaneous events:
  - tap_rst has priority over everything.
  - Sampled pad_tap_trst_n=0 forces TLR and reloads counters, and a pending switch is evaluated against the pre-edge state.
- tap_state leaving TLR in the same edge as a switch: the switch still applies, because the decision uses the pre-edge tap_state.
- After reset, selecting TAP 1 requires only that tap_state==TLR (counters preloaded to 5).

## Test plan
- Reset, pad_sel_tap=0, toggle TMS -> mux_tap_tms[0] follows pad TMS; mux_tap_tms[1]=1; act_sel=0; tap_state walks TLR→RTI→SelDR…
- In RTI, set pad_sel_tap=1 -> sel_pending=1, act_sel=0. Then drive 5 TMS=1 -> act_sel=1 at the edge where tap_state==TLR; sel_pending=0; pad_tap_tdo=mux_tap_tdo[1].
- NUM_TAPS=3, SEL_W=2, code 3, drive TMS to ShDR -> TDI propagates tdo0→tdi1, tdo1→tdi2, pad_tap_tdo=mux_tap_tdo[2], pad_tap_tdo_en=1 only in ShDR/ShIR.
- NUM_TAPS=2, code 2 -> sel_invalid=1, sel_pending=0, act_sel unchanged.
- In ShIR, drive pad_tap_trst_n=0 for 1 cycle -> tap_state=TLR next edge, counters=5, and a pending request applies on the following edge.
- Assert tap_rst mid-shift with act_sel=1 -> next edge act_sel=0, tap_state=TLR, all mux_tap_tms=1 while reset is held.
